// File: rtl/ascii_save_capture.sv
// Captures bytes written to the ACIA transmit register into a buffer and serves them
// to the HPS over the ioctl upload handshake (read latency 2, ioctl_wait for 1 cycle).
module ascii_save_capture #(
  parameter int unsigned ADDR_W    = 14,
  parameter bit          STRIP_NUL = 1'b1,
  parameter logic [7:0]  FILL_BYTE = 8'h1A
) (
  input  logic              i_clk,
  input  logic              i_n_reset,
  input  logic              i_capture_en,
  input  logic              i_tx_strobe,
  input  logic [7:0]        i_tx_data,
  input  logic              i_clear,
  input  logic              i_ioctl_upload,
  input  logic              i_ioctl_rd,
  input  logic [15:0]       i_ioctl_addr,
  output logic [7:0]        o_ioctl_din,
  output logic              o_ioctl_wait,
  output logic              o_upload_req,
  output logic [ADDR_W:0]   o_save_len,
  output logic              o_capturing,
  output logic              o_overflow
);

  localparam logic [ADDR_W:0] LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StCapture, StHold, StUpload} state_e;

  state_e            r_state, w_state_d;
  logic              r_cap_en, r_upload;
  logic [ADDR_W:0]   r_wr_ptr, w_wr_ptr_d;
  logic              r_overflow, w_overflow_d;
  logic              r_upload_req, w_upload_req_d;
  logic              r_capturing, w_capturing_d;
  logic              r_wait, r_fill;
  logic [7:0]        r_din, r_rd_data;
  logic [7:0]        r_mem [2**ADDR_W];

  logic              w_cap_rise, w_cap_fall, w_up_rise, w_up_fall;
  logic              w_accept, w_full, w_we, w_rd_go, w_fill;
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_cap_rise = i_capture_en & ~r_cap_en;
  assign w_cap_fall = ~i_capture_en & r_cap_en;
  assign w_up_rise  = i_ioctl_upload & ~r_upload;
  assign w_up_fall  = ~i_ioctl_upload & r_upload;
  assign w_accept   = i_tx_strobe & ~(STRIP_NUL & (i_tx_data == 8'h00));
  assign w_full     = (r_wr_ptr == LEN_FULL);
  // A second strobe while a read is outstanding is a protocol error and is dropped.
  assign w_rd_go    = (r_state == StUpload) & i_ioctl_rd & ~r_wait;
  assign w_fill     = 32'(i_ioctl_addr) >= 32'(r_wr_ptr);

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) r_state <= StIdle;
    else            r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_cap_rise)     w_state_d = StCapture;
        else if (w_up_rise) w_state_d = StUpload;
      end
      StCapture: begin
        if (w_cap_fall) w_state_d = (w_wr_ptr_d != '0) ? StHold : StIdle;
      end
      StHold: begin
        if (i_clear)         w_state_d = StIdle;
        else if (w_cap_rise) w_state_d = StCapture;
        else if (w_up_rise)  w_state_d = StUpload;
      end
      StUpload: begin
        if (w_up_fall) w_state_d = (r_wr_ptr != '0) ? StHold : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_upload_req_d = (r_state == StCapture) & w_cap_fall & (w_wr_ptr_d != '0);
    w_capturing_d  = (w_state_d == StCapture);
  end

  always_comb begin
    w_wr_ptr_d   = r_wr_ptr;
    w_overflow_d = r_overflow;
    w_we         = 1'b0;
    w_wr_addr    = r_wr_ptr[ADDR_W-1:0];
    unique case (r_state)
      StIdle, StHold: begin
        if (i_clear || w_cap_rise) begin
          w_wr_ptr_d   = '0;
          w_overflow_d = 1'b0;
        end
      end
      StCapture: begin
        if (i_clear) begin
          // Clear wins, but a byte arriving with it becomes the first entry.
          w_overflow_d = 1'b0;
          w_wr_addr    = '0;
          w_we         = w_accept;
          w_wr_ptr_d   = w_accept ? {{ADDR_W{1'b0}}, 1'b1} : '0;
        end else if (w_accept) begin
          if (w_full) begin
            w_overflow_d = 1'b1;
          end else begin
            w_we       = 1'b1;
            w_wr_ptr_d = r_wr_ptr + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_cap_en     <= 1'b0;
      r_upload     <= 1'b0;
      r_wr_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_upload_req <= 1'b0;
      r_capturing  <= 1'b0;
      r_wait       <= 1'b0;
      r_fill       <= 1'b0;
      r_din        <= 8'h00;
    end else begin
      r_cap_en     <= i_capture_en;
      r_upload     <= i_ioctl_upload;
      r_wr_ptr     <= w_wr_ptr_d;
      r_overflow   <= w_overflow_d;
      r_upload_req <= w_upload_req_d;
      r_capturing  <= w_capturing_d;
      r_wait       <= w_rd_go;
      if (w_rd_go) r_fill <= w_fill;
      if (r_wait)  r_din  <= r_fill ? FILL_BYTE : r_rd_data;
    end
  end

  // Buffer RAM: no reset so it maps onto block memory.
  always_ff @(posedge i_clk) begin
    if (w_we)    r_mem[w_wr_addr] <= i_tx_data;
    if (w_rd_go) r_rd_data <= r_mem[i_ioctl_addr[ADDR_W-1:0]];
  end

  assign o_ioctl_din  = r_din;
  assign o_ioctl_wait = r_wait;
  assign o_upload_req = r_upload_req;
  assign o_save_len   = r_wr_ptr;
  assign o_capturing  = r_capturing;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_ascii_save_capture.sv
// Directed bench for ascii_save_capture with a 16-byte buffer: cycle vector table plus
// hand-written overflow, clear, empty-capture and reset-mid-read sequences.
module tb_ascii_save_capture;

  logic        clk, n_reset;
  logic        cap_en, tx_strobe, clear, upload, rd;
  logic [7:0]  tx_data;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        wait_o, req, capturing, overflow;
  logic [4:0]  save_len;

  int n_cmp = 0;
  int n_err = 0;

  ascii_save_capture #(.ADDR_W(4), .STRIP_NUL(1'b1), .FILL_BYTE(8'h1A)) dut (
    .i_clk(clk), .i_n_reset(n_reset), .i_capture_en(cap_en), .i_tx_strobe(tx_strobe),
    .i_tx_data(tx_data), .i_clear(clear), .i_ioctl_upload(upload), .i_ioctl_rd(rd),
    .i_ioctl_addr(addr), .o_ioctl_din(din), .o_ioctl_wait(wait_o), .o_upload_req(req),
    .o_save_len(save_len), .o_capturing(capturing), .o_overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic cap, stb; logic [7:0] dat; logic clr, up, rd; logic [15:0] addr;
    logic [7:0] e_din; logic e_wait, e_req; logic [4:0] e_len; logic e_cap, e_ovf;
  } vec_t;

  function automatic vec_t mk(logic cap, logic stb, logic [7:0] dat, logic clr, logic up,
                              logic rdv, logic [15:0] a, logic [7:0] e_din, logic e_wait,
                              logic e_req, logic [4:0] e_len, logic e_cap, logic e_ovf);
    vec_t v;
    v.cap = cap; v.stb = stb; v.dat = dat; v.clr = clr; v.up = up; v.rd = rdv; v.addr = a;
    v.e_din = e_din; v.e_wait = e_wait; v.e_req = e_req; v.e_len = e_len;
    v.e_cap = e_cap; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upload_read(input logic [15:0] a, input logic [7:0] exp);
    rd = 1'b1; addr = a;
    tick();
    rd = 1'b0;
    chk($sformatf("rd%0d.wait_hi", a), 32'(wait_o), 32'd1);
    tick();
    chk($sformatf("rd%0d.wait_lo", a), 32'(wait_o), 32'd0);
    chk($sformatf("rd%0d.din", a), 32'(din), 32'(exp));
  endtask

  vec_t vecs[26];

  initial begin
    // Scenario: capture "1",NUL,CR,LF; upload it, including an ignored strobe mid-read.
    vecs[0]  = mk(1,0,8'h00,0,0,0,0, 8'h00,0,0,0,1,0);
    vecs[1]  = mk(1,1,8'h31,0,0,0,0, 8'h00,0,0,1,1,0);
    vecs[2]  = mk(1,1,8'h00,0,0,0,0, 8'h00,0,0,1,1,0);
    vecs[3]  = mk(1,1,8'h0D,0,0,0,0, 8'h00,0,0,2,1,0);
    vecs[4]  = mk(1,1,8'h0A,0,0,0,0, 8'h00,0,0,3,1,0);
    vecs[5]  = mk(0,0,8'h00,0,0,0,0, 8'h00,0,1,3,0,0);
    vecs[6]  = mk(0,0,8'h00,0,0,0,0, 8'h00,0,0,3,0,0);
    vecs[7]  = mk(0,0,8'h00,0,1,0,0, 8'h00,0,0,3,0,0);
    vecs[8]  = mk(0,0,8'h00,0,1,1,0, 8'h00,1,0,3,0,0);
    vecs[9]  = mk(0,1,8'h41,0,1,0,0, 8'h31,0,0,3,0,0);
    vecs[10] = mk(0,0,8'h00,0,1,1,1, 8'h31,1,0,3,0,0);
    vecs[11] = mk(0,0,8'h00,0,1,0,0, 8'h0D,0,0,3,0,0);
    vecs[12] = mk(0,0,8'h00,0,1,1,2, 8'h0D,1,0,3,0,0);
    vecs[13] = mk(0,0,8'h00,0,1,0,0, 8'h0A,0,0,3,0,0);
    vecs[14] = mk(0,0,8'h00,0,1,1,3, 8'h0A,1,0,3,0,0);
    vecs[15] = mk(0,0,8'h00,0,1,0,0, 8'h1A,0,0,3,0,0);
    vecs[16] = mk(0,0,8'h00,0,1,1,0, 8'h1A,1,0,3,0,0);
    vecs[17] = mk(0,0,8'h00,0,1,1,1, 8'h31,0,0,3,0,0);
    vecs[18] = mk(0,0,8'h00,0,1,0,0, 8'h31,0,0,3,0,0);
    vecs[19] = mk(0,0,8'h00,0,0,0,0, 8'h31,0,0,3,0,0);
    vecs[20] = mk(0,1,8'h55,0,0,0,0, 8'h31,0,0,3,0,0);
    vecs[21] = mk(0,0,8'h00,0,1,0,0, 8'h31,0,0,3,0,0);
    vecs[22] = mk(0,0,8'h00,0,1,1,2, 8'h31,1,0,3,0,0);
    vecs[23] = mk(0,0,8'h00,0,1,0,0, 8'h0A,0,0,3,0,0);
    vecs[24] = mk(0,0,8'h00,1,1,0,0, 8'h0A,0,0,3,0,0);
    vecs[25] = mk(0,0,8'h00,0,0,0,0, 8'h0A,0,0,3,0,0);

    n_reset = 1'b0; cap_en = 1'b0; tx_strobe = 1'b0; tx_data = 8'h00; clear = 1'b0;
    upload = 1'b0; rd = 1'b0; addr = 16'h0000;
    #3;
    chk("rst.din", 32'(din), 32'd0);
    chk("rst.wait", 32'(wait_o), 32'd0);
    chk("rst.req", 32'(req), 32'd0);
    chk("rst.len", 32'(save_len), 32'd0);
    chk("rst.capturing", 32'(capturing), 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    tick();
    tick();
    n_reset = 1'b1;

    for (int i = 0; i < 26; i++) begin
      cap_en = vecs[i].cap; tx_strobe = vecs[i].stb; tx_data = vecs[i].dat;
      clear = vecs[i].clr; upload = vecs[i].up; rd = vecs[i].rd; addr = vecs[i].addr;
      tick();
      chk($sformatf("v%0d.din", i), 32'(din), 32'(vecs[i].e_din));
      chk($sformatf("v%0d.wait", i), 32'(wait_o), 32'(vecs[i].e_wait));
      chk($sformatf("v%0d.req", i), 32'(req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d.len", i), 32'(save_len), 32'(vecs[i].e_len));
      chk($sformatf("v%0d.capturing", i), 32'(capturing), 32'(vecs[i].e_cap));
      chk($sformatf("v%0d.overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
    end
    tx_strobe = 1'b0; clear = 1'b0; rd = 1'b0; upload = 1'b0; cap_en = 1'b0;

    // Overflow: 17 bytes into a 16-byte buffer, byte 17 must be absent.
    cap_en = 1'b1;
    tick();
    chk("ovf.arm_len", 32'(save_len), 32'd0);
    chk("ovf.arm_capturing", 32'(capturing), 32'd1);
    for (int i = 1; i <= 17; i++) begin
      tx_strobe = 1'b1; tx_data = 8'(i);
      tick();
      if (i == 16) chk("ovf.at16_overflow", 32'(overflow), 32'd0);
    end
    tx_strobe = 1'b0;
    chk("ovf.len", 32'(save_len), 32'd16);
    chk("ovf.overflow", 32'(overflow), 32'd1);
    cap_en = 1'b0;
    tick();
    chk("ovf.req", 32'(req), 32'd1);
    upload = 1'b1;
    tick();
    upload_read(16'd15, 8'h10);
    upload_read(16'd16, 8'h1A);
    upload_read(16'h0100, 8'h1A);
    upload = 1'b0;
    tick();
    cap_en = 1'b1;
    tick();
    chk("rearm.overflow", 32'(overflow), 32'd0);
    chk("rearm.len", 32'(save_len), 32'd0);

    // Clear together with a strobe: the byte lands at address 0.
    tx_strobe = 1'b1; tx_data = 8'h33;
    tick();
    chk("clr.pre_len", 32'(save_len), 32'd1);
    clear = 1'b1; tx_data = 8'h42;
    tick();
    clear = 1'b0;
    chk("clr.len", 32'(save_len), 32'd1);
    tx_data = 8'h43;
    tick();
    tx_strobe = 1'b0;
    chk("clr.len2", 32'(save_len), 32'd2);
    cap_en = 1'b0;
    tick();
    chk("clr.req", 32'(req), 32'd1);
    upload = 1'b1;
    tick();
    upload_read(16'd0, 8'h42);
    upload_read(16'd1, 8'h43);
    upload = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("hold_clear.len", 32'(save_len), 32'd0);

    // Empty capture: no upload request.
    cap_en = 1'b1;
    tick();
    chk("empty.capturing", 32'(capturing), 32'd1);
    cap_en = 1'b0;
    tick();
    chk("empty.req", 32'(req), 32'd0);
    chk("empty.capturing_off", 32'(capturing), 32'd0);
    tick();
    chk("empty.req_later", 32'(req), 32'd0);

    // Reset in the middle of a read.
    upload = 1'b1;
    tick();
    rd = 1'b1; addr = 16'd0;
    tick();
    rd = 1'b0;
    chk("midrst.wait_before", 32'(wait_o), 32'd1);
    chk("midrst.din_before", 32'(din), 32'h43);
    n_reset = 1'b0;
    #1;
    chk("midrst.wait", 32'(wait_o), 32'd0);
    chk("midrst.din", 32'(din), 32'd0);
    tick();
    chk("midrst.wait_held", 32'(wait_o), 32'd0);
    chk("midrst.din_held", 32'(din), 32'd0);
    chk("midrst.req", 32'(req), 32'd0);
    upload = 1'b0;
    n_reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
